// File: rtl/sum_req_initiator.sv
// Purpose: issues one start/valid sum request per upstream operand pair and returns the result with timeout/mismatch status.
// Latency: accept at edge N, start during N+1, out_valid at N+3 for a 1-cycle responder, N+2+TIMEOUT on timeout.
// Backpressure: one transaction in flight; in_ready only in IDLE, result held in RESP until out_ready.
module sum_req_initiator #(
    parameter int W       = 10,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             start,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    input  logic [W-1:0]     y,
    input  logic             valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic             out_timeout,
    output logic             out_mismatch,
    output logic             proto_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    // Timer counts completed WAIT cycles; TIMEOUT-1 marks the last one.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic          accept;
    logic          resp_hs;
    logic          got_rsp;
    logic          expire;
    logic [W-1:0]  sum;

    assign accept  = in_valid && in_ready;
    assign resp_hs = out_valid && out_ready;
    assign got_rsp = (state == WAIT) && valid;
    // A valid arriving in the final WAIT cycle wins over the timeout.
    assign expire  = (state == WAIT) && !valid && (timer == TLAST);
    // Truncating add: carry is intentionally dropped for the compare.
    assign sum     = a + b;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (got_rsp || expire) state_nxt = RESP;
            RESP:    if (resp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Upstream ready is the only output decoded straight from the state.
    always_comb begin
        in_ready = (state == IDLE);
    end

    // Operand capture and the one-cycle start pulse for the ISSUE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= '0;
            b     <= '0;
            start <= 1'b0;
        end else begin
            start <= accept;
            if (accept) begin
                a <= in_a;
                b <= in_b;
            end
        end
    end

    // WAIT-cycle timer: cleared while issuing, advanced per WAIT cycle without valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      timer <= '0;
        else if (state == ISSUE)         timer <= '0;
        else if (state == WAIT && !valid) timer <= timer + TW'(1);
    end

    // Result capture on response or timeout; held until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_y        <= '0;
            out_timeout  <= 1'b0;
            out_mismatch <= 1'b0;
        end else if (got_rsp) begin
            out_valid    <= 1'b1;
            out_y        <= y;
            out_timeout  <= 1'b0;
            out_mismatch <= (y != sum);
        end else if (expire) begin
            out_valid    <= 1'b1;
            out_y        <= '0;
            out_timeout  <= 1'b1;
            out_mismatch <= 1'b0;
        end else if (resp_hs) begin
            out_valid    <= 1'b0;
        end
    end

    // Sticky protocol error: responder valid outside WAIT is never used as data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      proto_err <= 1'b0;
        else if (valid && state != WAIT) proto_err <= 1'b1;
    end

    // Saturating counters bumped on each downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (resp_hs) begin
            if (txn_count != '1)
                txn_count <= txn_count + CNT_W'(1);
            if ((out_timeout || out_mismatch) && err_count != '1)
                err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/sum_req_initiator.md
# sum_req_initiator

Initiator side of the single-cycle start/valid sum protocol. Accepts operand pairs on an upstream ready/valid port, drives a one-cycle `start` pulse with stable operands to a sum responder, waits for its `valid` with a bounded timeout, and returns the captured result downstream with timeout and mismatch status. It sits between the operand source and the responder, and keeps transaction and error counters for the bench and software.

## Interface
- `W`, 10, operand and result width
- `TIMEOUT`, 4, WAIT cycles without `valid` before the transaction is declared timed out (≥1)
- `CNT_W`, 16, width of `txn_count` and `err_count`
- `clk` input 1 clock
- `rst_n` input 1 reset, asynchronous, active-low
- `in_valid` input 1 upstream operand pair valid
- `in_ready` output 1 initiator can accept an operand pair
- `in_a`, `in_b` input W upstream operands
- `start` output 1 request pulse to the responder
- `a`, `b` output W operands to the responder, held stable from ISSUE through the end of WAIT
- `y` input W responder result
- `valid` input 1 responder result valid
- `out_valid` output 1 downstream result valid
- `out_ready` input 1 downstream accepts result
- `out_y` output W captured result (0 on timeout)
- `out_timeout` output 1 response ended by timeout
- `out_mismatch` output 1 captured `y` ≠ (`a`+`b`) mod 2^W
- `proto_err` output 1 sticky flag: `valid` seen outside WAIT
- `txn_count` output CNT_W completed downstream handshakes, saturating
- `err_count` output CNT_W responses with `out_timeout` or `out_mismatch` set, saturating

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state: IDLE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, register `in_a`/`in_b` into `a`/`b` and go to ISSUE.
- ISSUE: `start`=1 for exactly this cycle. Clear the timer and go to WAIT.
- WAIT: `start`=0. If `valid`=1: capture `y` into `out_y`, set `out_mismatch` from the W-bit compare, clear `out_timeout`, go to RESP. Otherwise increment the timer. When the timer reaches TIMEOUT with no `valid`: `out_y`=0, `out_timeout`=1, `out_mismatch`=0, go to RESP.
- RESP: `out_valid`=1. `out_y`/`out_timeout`/`out_mismatch` hold until `out_valid`&&`out_ready`. On that handshake:
  - increment `txn_count`
  - increment `err_count` if either status bit is set
  - clear `out_valid`
  - go to IDLE
- `in_ready`=0 in ISSUE, WAIT and RESP. The block has no operand buffering and one transaction in flight.
- Sum compare uses a W-bit truncating add; the carry is discarded.
- `valid` in IDLE, ISSUE or RESP is ignored for data and sets `proto_err`. `proto_err` clears only on reset.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- Reset, asynchronous at any point including mid-transaction:
  - FSM returns to IDLE
  - `start`, `out_valid`, `out_timeout`, `out_mismatch`, `proto_err` = 0
  - `a`, `b`, `out_y`, `txn_count`, `err_count` = 0
  - `in_ready`=1 once the FSM is in IDLE
  - any in-flight transaction is dropped

## Timing
- All outputs are registered, except `in_ready`, which decodes from the state register.
- Upstream accept at edge N; `start`=1 during cycle N+1; `valid` expected during cycle N+2. `out_valid` rises at N+3 for the nominal 1-cycle responder.
- Minimum period is 4 cycles per transaction with `out_ready` tied high. The next accept occurs in the cycle after the downstream handshake.
- The timeout fires after TIMEOUT consecutive WAIT cycles without `valid`. With TIMEOUT=4 and no response: `start` at N+1, `out_valid`/`out_timeout` rise at N+6.
- `valid` in the same cycle the timer expires counts as a response, not a timeout.
- Late `valid` after a timeout (in RESP) is ignored and sets `proto_err`.
- `a`/`b` must not change while `start` is high or during WAIT.

## Test plan
- Reset mid-WAIT: assert `rst_n`=0 during WAIT → `start`=0, `out_valid`=0, counters 0 immediately; `in_ready`=1 after release.
- Nominal: `in_a`=3, `in_b`=4, responder returns `y`=7 one cycle after `start` → `out_valid` at N+3, `out_y`=7, status bits 0, `txn_count`=1.
- Wrap: `in_a`=700, `in_b`=500, `y`=176 → `out_mismatch`=0. `y`=1200 truncated to 176 is correct; `y`=177 → `out_mismatch`=1, `err_count`=1.
- Timeout: responder never asserts `valid`, TIMEOUT=4 → `out_timeout`=1, `out_y`=0, `out_valid` at N+6. A late `valid` in RESP → `proto_err`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid`/`out_y` stable, `in_ready`=0, `start` not reasserted. Release → one handshake, `txn_count` +1.
- Back-to-back: 10 random pairs with `in_valid` held high and `out_ready`=1 → exactly 10 `start` pulses 4 cycles apart, all sums correct, `txn_count`=10, `err_count`=0.
